// File: rtl/pe_network_interface.sv
// pe_network_interface: PE-to-switch adapter with TX FIFO, address-checking RX register and traffic counters
module pe_network_interface #(
    parameter int DataWidth = 36,
    parameter int AddrWidth = 4,
    parameter int MyAddr = 0,
    parameter int TxDepth = 4,
    parameter int CntWidth = 16
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
    input  logic [AddrWidth-1:0]           i_pe_dest,
    input  logic                           i_pe_valid,
    output logic                           o_pe_ready,
    output logic [DataWidth-1:0]           o_data,
    output logic                           o_data_valid,
    input  logic                           i_data_ready,
    input  logic [DataWidth-1:0]           i_data,
    input  logic                           i_data_valid,
    output logic                           o_data_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_rx_data,
    output logic                           o_pe_rx_valid,
    input  logic                           i_pe_rx_ready,
    output logic [CntWidth-1:0]            o_tx_cnt,
    output logic [CntWidth-1:0]            o_rx_cnt,
    output logic [CntWidth-1:0]            o_misroute_cnt
);
    localparam int PW = DataWidth - AddrWidth;
    localparam int PtrW = $clog2(TxDepth);
    logic [DataWidth-1:0] mem [TxDepth];
    logic [PtrW-1:0] rd_ptr, wr_ptr;
    logic [PtrW:0] count;
    logic push, pop, accept, good, bad, drain, rx_v;
    logic [PW-1:0] rx_data;
    assign o_pe_ready = count != (PtrW+1)'(TxDepth);
    assign o_data_valid = count != '0;
    assign o_data = mem[rd_ptr];
    assign push = i_pe_valid & o_pe_ready;
    assign pop = o_data_valid & i_data_ready;
    assign o_data_ready = !rx_v | i_pe_rx_ready;
    assign accept = i_data_valid & o_data_ready;
    assign good = accept & (i_data[DataWidth-1 -: AddrWidth] == AddrWidth'(MyAddr));
    assign bad = accept & !good;
    assign drain = rx_v & i_pe_rx_ready;
    assign o_pe_rx_valid = rx_v;
    assign o_pe_rx_data = rx_data;
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_pe_dest, i_pe_data};
        if (good) rx_data <= i_data[PW-1:0];
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            rx_v <= 1'b0;
            o_tx_cnt <= '0;
            o_rx_cnt <= '0;
            o_misroute_cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + PtrW'(push);
            rd_ptr <= rd_ptr + PtrW'(pop);
            count <= count + (PtrW+1)'(push) - (PtrW+1)'(pop);
            rx_v <= good | (rx_v & !drain);
            o_tx_cnt <= o_tx_cnt + CntWidth'(pop);
            o_rx_cnt <= o_rx_cnt + CntWidth'(drain);
            o_misroute_cnt <= (bad && !(&o_misroute_cnt)) ? o_misroute_cnt + CntWidth'(1) : o_misroute_cnt;
        end
    end
endmodule
